// File: rtl/chan_550_dac_start_ctrl.sv
// DAC bring-up sequencer: reset, lock-wait, LUT prime and run, driven by the start-DAC register word.
// Optional macro SYNC_ALIGN_EN adds WAIT_SYNC so DAC reset is aligned to an external sync_in edge.
module chan_550_dac_start_ctrl #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 4096,
   parameter int unsigned PRIME_CYCLES = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic        user_clk,
   input  logic        user_rst_n,
   input  logic [31:0] ctrl_word,
   input  logic        sync_in,
   input  logic        dac_locked,
   output logic        dac_rst,
   output logic        lut_addr_rst,
   output logic        dac_en,
   output logic [31:0] status
);

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_SYNC = 3'd1,
      S_DAC_RST   = 3'd2,
      S_WAIT_LOCK = 3'd3,
      S_PRIME     = 3'd4,
      S_RUN       = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       r_starts;
   logic [7:0]       w_starts_nxt;
   logic             r_start_q;
   logic             r_clr_q;
   logic             r_lock_meta;
   logic             r_lock_sync;
   logic             w_start_rise;
   logic             w_clr_rise;
   logic             w_stop;
   logic             w_dac_rst_nxt;
   logic             w_lut_rst_nxt;
   logic             w_dac_en_nxt;
   logic [31:0]      w_status_nxt;

   assign w_start_rise = ctrl_word[0] & ~r_start_q;
   assign w_clr_rise   = ctrl_word[2] & ~r_clr_q;
   assign w_stop       = ctrl_word[1];

`ifdef SYNC_ALIGN_EN
   logic r_sync_q;
   logic r_sync_qq;
   logic w_sync_rise;
   logic w_unused;

   assign w_sync_rise = r_sync_q & ~r_sync_qq;
   assign w_unused    = &{1'b0, ctrl_word[31:3]};

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         r_sync_q  <= 1'b0;
         r_sync_qq <= 1'b0;
      end else begin
         r_sync_q  <= sync_in;
         r_sync_qq <= r_sync_q;
      end
   end
`else
   logic w_unused;
   assign w_unused = &{1'b0, ctrl_word[31:3], sync_in};
`endif

   // Edge-detect history resets high so a bit held through reset is not seen as a rise.
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         r_start_q   <= 1'b1;
         r_clr_q     <= 1'b1;
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_start_q   <= ctrl_word[0];
         r_clr_q     <= ctrl_word[2];
         r_lock_meta <= dac_locked;
         r_lock_sync <= r_lock_meta;
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_starts     <= '0;
         dac_rst      <= 1'b0;
         lut_addr_rst <= 1'b0;
         dac_en       <= 1'b0;
         status       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_starts     <= w_starts_nxt;
         dac_rst      <= w_dac_rst_nxt;
         lut_addr_rst <= w_lut_rst_nxt;
         dac_en       <= w_dac_en_nxt;
         status       <= w_status_nxt;
      end
   end

   // Next state; outputs decode the next state so they move on the same edge as r_state.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_starts_nxt = r_starts;

      case (r_state)
         S_IDLE: begin
            if (w_start_rise && !w_stop) begin
`ifdef SYNC_ALIGN_EN
               w_state_nxt = S_WAIT_SYNC;
`else
               w_state_nxt = S_DAC_RST;
`endif
               w_starts_nxt = r_starts + 8'd1;
               w_cnt_nxt    = '0;
            end
         end
`ifdef SYNC_ALIGN_EN
         S_WAIT_SYNC: begin
            if (w_sync_rise) begin
               w_state_nxt = S_DAC_RST;
               w_cnt_nxt   = '0;
            end
         end
`endif
         S_DAC_RST: begin
            if (r_cnt == RST_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (r_lock_sync) begin
               w_state_nxt = S_PRIME;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LOCK_LAST) begin
               w_state_nxt = S_FAULT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_PRIME: begin
            if (r_cnt == PRIME_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!r_lock_sync) begin
               w_state_nxt = S_FAULT;
            end
         end
         S_FAULT: begin
            if (w_clr_rise) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Stop overrides everything except a latched fault.
      if (w_stop && (r_state != S_FAULT)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end

      w_dac_rst_nxt = (w_state_nxt == S_DAC_RST) || (w_state_nxt == S_FAULT);
      w_lut_rst_nxt = (w_state_nxt == S_PRIME);
      w_dac_en_nxt  = (w_state_nxt == S_RUN);
      w_status_nxt  = {16'd0, w_starts_nxt, 3'd0,
                       (w_state_nxt == S_FAULT), (w_state_nxt == S_RUN), 3'(w_state_nxt)};
   end

endmodule
